// File: rtl/riscv_core_csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for a small RISC-V core.
// Accepts one instruction per idle cycle, executes Zicsr accesses to the
// supported machine CSRs, and sequences ecall/ebreak/illegal/interrupt traps
// and mret through a short TRAP/RET redirect state.
module riscv_core_csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_irq,
  output logic            o_busy,
  output logic            o_rd_wen,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_illegal
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  localparam logic [XLEN-1:0] ALIGN_MASK        = ~(XLEN'(3));
  localparam logic [XLEN-1:0] MTVEC_RESET_VALUE = RESET_MTVEC & ALIGN_MASK;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL     = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL_M     = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MEXT_IRQ    = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  // The high half of the cycle counter only has its own CSR on RV32.
  localparam logic            HAS_MCYCLEH       = (XLEN == 32);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Architectural CSR state; only implemented bits are stored.
  logic            mstatus_mie_reg,  mstatus_mie_next;
  logic            mstatus_mpie_reg, mstatus_mpie_next;
  logic            mie_meie_reg,     mie_meie_next;
  logic [XLEN-1:0] mtvec_reg,        mtvec_next;
  logic [XLEN-1:0] mscratch_reg,     mscratch_next;
  logic [XLEN-1:0] mepc_reg,         mepc_next;
  logic [XLEN-1:0] mcause_reg,       mcause_next;
  logic [63:0]     cycle_reg,        cycle_next;

  // Registered outputs.
  logic            rd_wen_reg,      rd_wen_next;
  logic [XLEN-1:0] rd_data_reg,     rd_data_next;
  logic            redirect_reg,    redirect_next;
  logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
  logic            illegal_reg,     illegal_next;

  // Instruction fields.
  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [2:0]  funct3;
  logic [4:0]  rs1_field;
  logic [11:0] csr_addr;

  assign opcode    = i_instr[6:0];
  assign rd_idx    = i_instr[11:7];
  assign funct3    = i_instr[14:12];
  assign rs1_field = i_instr[19:15];
  assign csr_addr  = i_instr[31:20];

  // Decode results.
  logic is_system;
  logic is_ecall;
  logic is_ebreak;
  logic is_mret;
  logic is_wfi;
  logic is_csr;
  logic csr_write;
  logic csr_supported;
  logic csr_read_only;
  logic is_illegal;

  // Instruction classification and legality checks
  always_comb begin
    is_system = (opcode == 7'h73);
    is_ecall  = (i_instr == INSTR_ECALL);
    is_ebreak = (i_instr == INSTR_EBREAK);
    is_mret   = (i_instr == INSTR_MRET);
    is_wfi    = (i_instr == INSTR_WFI);
    // funct3 000 and 100 are not CSR accesses; every other value is.
    is_csr    = is_system && (funct3[1:0] != 2'b00);
    // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero source field.
    csr_write = is_csr && ((funct3[1:0] == 2'b01) || (rs1_field != 5'd0));

    case (csr_addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MIP, CSR_MCYCLE: csr_supported = 1'b1;
      CSR_MCYCLEH:                     csr_supported = HAS_MCYCLEH;
      default:                         csr_supported = 1'b0;
    endcase

    csr_read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MIP);

    is_illegal = is_system && (
                   ((funct3 == 3'b000) && !(is_ecall || is_ebreak || is_mret || is_wfi)) ||
                   (funct3 == 3'b100) ||
                   (is_csr && (!csr_supported || (csr_write && csr_read_only))));
  end

  // CSR read mux and read-modify-write data
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] csr_operand;
  logic [XLEN-1:0] csr_wdata;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[3] = mstatus_mie_reg;
        csr_rdata[7] = mstatus_mpie_reg;
      end
      CSR_MIE:      csr_rdata[11] = mie_meie_reg;
      CSR_MTVEC:    csr_rdata     = mtvec_reg;
      CSR_MSCRATCH: csr_rdata     = mscratch_reg;
      CSR_MEPC:     csr_rdata     = mepc_reg;
      CSR_MCAUSE:   csr_rdata     = mcause_reg;
      CSR_MIP:      csr_rdata[11] = i_irq;
      CSR_MCYCLE:   csr_rdata     = cycle_reg[XLEN-1:0];
      CSR_MCYCLEH:  csr_rdata     = XLEN'(cycle_reg[63:32]);
      default:      csr_rdata     = '0;
    endcase

    // Immediate forms use the zero-extended rs1 field as the operand.
    csr_operand = funct3[2] ? XLEN'(rs1_field) : i_rs1_data;

    case (funct3[1:0])
      2'b01:   csr_wdata = csr_operand;
      2'b10:   csr_wdata = csr_rdata | csr_operand;
      default: csr_wdata = csr_rdata & ~csr_operand;
    endcase
  end

  // Acceptance and priority: interrupt > illegal > ecall/ebreak > CSR/mret.
  logic accept;
  logic take_irq;
  logic take_illegal;
  logic take_exc;
  logic take_mret;
  logic do_csr;

  assign accept       = i_valid && (state_reg == ST_IDLE);
  assign take_irq     = accept && i_irq && mstatus_mie_reg && mie_meie_reg;
  assign take_illegal = accept && !take_irq && is_illegal;
  assign take_exc     = accept && !take_irq && !is_illegal && (is_ecall || is_ebreak);
  assign take_mret    = accept && !take_irq && !is_illegal && is_mret;
  assign do_csr       = accept && !take_irq && !is_illegal && is_csr;

  // Next-state logic for the FSM, CSR file, cycle counter and registered outputs
  always_comb begin
    state_next        = state_reg;
    mstatus_mie_next  = mstatus_mie_reg;
    mstatus_mpie_next = mstatus_mpie_reg;
    mie_meie_next     = mie_meie_reg;
    mtvec_next        = mtvec_reg;
    mscratch_next     = mscratch_reg;
    mepc_next         = mepc_reg;
    mcause_next       = mcause_reg;
    cycle_next        = cycle_reg + 64'd1;
    rd_wen_next       = 1'b0;
    rd_data_next      = '0;
    redirect_next     = 1'b0;
    redirect_pc_next  = '0;
    illegal_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (take_irq || take_illegal || take_exc) begin
          // The redirect pulse is raised in the TRAP cycle itself.
          state_next       = ST_TRAP;
          mepc_next        = i_pc & ALIGN_MASK;
          redirect_next    = 1'b1;
          redirect_pc_next = mtvec_reg;
          if (take_irq) begin
            mcause_next = CAUSE_MEXT_IRQ;
          end else if (take_illegal) begin
            mcause_next  = CAUSE_ILLEGAL;
            illegal_next = 1'b1;
          end else if (is_ebreak) begin
            mcause_next = CAUSE_BREAKPOINT;
          end else begin
            mcause_next = CAUSE_ECALL_M;
          end
        end else if (take_mret) begin
          state_next       = ST_RET;
          redirect_next    = 1'b1;
          redirect_pc_next = mepc_reg;
        end else if (do_csr) begin
          rd_wen_next  = (rd_idx != 5'd0);
          rd_data_next = csr_rdata;
          if (csr_write) begin
            case (csr_addr)
              CSR_MSTATUS: begin
                mstatus_mie_next  = csr_wdata[3];
                mstatus_mpie_next = csr_wdata[7];
              end
              CSR_MIE:      mie_meie_next           = csr_wdata[11];
              CSR_MTVEC:    mtvec_next              = csr_wdata & ALIGN_MASK;
              CSR_MSCRATCH: mscratch_next           = csr_wdata;
              CSR_MEPC:     mepc_next               = csr_wdata & ALIGN_MASK;
              CSR_MCAUSE:   mcause_next             = csr_wdata;
              // A software write wins over the increment for the written half only.
              CSR_MCYCLE:   cycle_next[XLEN-1:0]    = csr_wdata;
              CSR_MCYCLEH:  cycle_next[63:32]       = csr_wdata[31:0];
              default:      ;
            endcase
          end
        end
      end
      ST_TRAP: begin
        mstatus_mpie_next = mstatus_mie_reg;
        mstatus_mie_next  = 1'b0;
        state_next        = ST_IDLE;
      end
      ST_RET: begin
        mstatus_mie_next  = mstatus_mpie_reg;
        mstatus_mpie_next = 1'b1;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset overrides everything, including a pending redirect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg        <= ST_IDLE;
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_meie_reg     <= 1'b0;
      mtvec_reg        <= MTVEC_RESET_VALUE;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      cycle_reg        <= '0;
      rd_wen_reg       <= 1'b0;
      rd_data_reg      <= '0;
      redirect_reg     <= 1'b0;
      redirect_pc_reg  <= '0;
      illegal_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mstatus_mie_reg  <= mstatus_mie_next;
      mstatus_mpie_reg <= mstatus_mpie_next;
      mie_meie_reg     <= mie_meie_next;
      mtvec_reg        <= mtvec_next;
      mscratch_reg     <= mscratch_next;
      mepc_reg         <= mepc_next;
      mcause_reg       <= mcause_next;
      cycle_reg        <= cycle_next;
      rd_wen_reg       <= rd_wen_next;
      rd_data_reg      <= rd_data_next;
      redirect_reg     <= redirect_next;
      redirect_pc_reg  <= redirect_pc_next;
      illegal_reg      <= illegal_next;
    end
  end

  assign o_busy        = (state_reg != ST_IDLE);
  assign o_rd_wen      = rd_wen_reg;
  assign o_rd_data     = rd_data_reg;
  assign o_redirect    = redirect_reg;
  assign o_redirect_pc = redirect_pc_reg;
  assign o_illegal     = illegal_reg;

endmodule

// File: tb/tb_riscv_core_csr_trap_unit.sv
// Scoreboard bench for riscv_core_csr_trap_unit (XLEN=32): directed scenarios
// followed by randomized instruction streams against a behavioural model.
module tb_riscv_core_csr_trap_unit;

  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_MTVEC = 32'h0000_0203;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic        irq = 1'b0;
  logic        busy;
  logic        rd_wen;
  logic [31:0] rd_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        illegal;

  riscv_core_csr_trap_unit #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_instr       (instr),
    .i_pc          (pc),
    .i_rs1_data    (rs1_data),
    .i_irq         (irq),
    .o_busy        (busy),
    .o_rd_wen      (rd_wen),
    .o_rd_data     (rd_data),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_illegal     (illegal)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int txn_count    = 0;

  typedef struct {
    logic        rd_wen;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Behavioural model of the architectural state.
  logic        m_busy = 1'b0;
  logic        m_trap = 1'b0;
  logic        m_mie = 1'b0, m_mpie = 1'b0, m_meie = 1'b0;
  logic [31:0] m_mtvec = '0, m_mscratch = '0, m_mepc = '0, m_mcause = '0;
  logic [63:0] m_cycle = '0;

  logic [11:0] addr_pool [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic [31:0] rdd, input logic rdr,
                              input logic [31:0] rpc, input logic ill);
    exp_t e;
    e.rd_wen = rw; e.rd_data = rdd; e.redirect = rdr; e.redirect_pc = rpc; e.illegal = ill;
    return e;
  endfunction

  function automatic logic csr_known(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h305) || (a == 12'h340) ||
           (a == 12'h341) || (a == 12'h342) || (a == 12'h344) || (a == 12'hB00) ||
           (a == 12'hB80);
  endfunction

  function automatic logic [31:0] csr_read(input logic [11:0] a, input logic irq_lvl);
    case (a)
      12'h300: return ({31'b0, m_mie} << 3) | ({31'b0, m_mpie} << 7);
      12'h304: return {31'b0, m_meie} << 11;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return {31'b0, irq_lvl} << 11;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_trap = 1'b0;
    m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0;
    m_mtvec = RESET_MTVEC & 32'hFFFF_FFFC;
    m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_cycle = '0;
  endtask

  task automatic model_trap(input logic [31:0] p, input logic [31:0] cause, input logic ill);
    exp_q.push_back(mk(1'b0, 32'h0, 1'b1, m_mtvec, ill));
    m_mepc   = p & 32'hFFFF_FFFC;
    m_mcause = cause;
    m_busy   = 1'b1;
    m_trap   = 1'b1;
  endtask

  // One clock cycle: check busy, drive inputs, advance the model, wait for the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] r1, input logic ir, input logic rs);
    logic [2:0]  f3;
    logic [4:0]  rdi, rs1f;
    logic [11:0] a;
    logic [31:0] old, opnd, nv, lo_val, hi_val;
    logic        wr, wr_lo, wr_hi;
    logic [63:0] inc;
    check("busy", 32'(busy), 32'(m_busy));
    rst = rs; valid = v; instr = ins; pc = p; rs1_data = r1; irq = ir;
    wr_lo = 1'b0; wr_hi = 1'b0; lo_val = '0; hi_val = '0; nv = '0;
    if (rs) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (m_trap) begin
          m_mpie = m_mie; m_mie = 1'b0;
        end else begin
          m_mie = m_mpie; m_mpie = 1'b1;
        end
        m_busy = 1'b0;
      end else if (v) begin
        f3 = ins[14:12]; rdi = ins[11:7]; rs1f = ins[19:15]; a = ins[31:20];
        if (ir && m_mie && m_meie) begin
          model_trap(p, 32'h8000_000B, 1'b0);
        end else if (ins[6:0] == 7'h73) begin
          if (f3 == 3'b000) begin
            if (ins == 32'h0000_0073)      model_trap(p, 32'd11, 1'b0);
            else if (ins == 32'h0010_0073) model_trap(p, 32'd3, 1'b0);
            else if (ins == 32'h3020_0073) begin
              exp_q.push_back(mk(1'b0, 32'h0, 1'b1, m_mepc, 1'b0));
              m_busy = 1'b1; m_trap = 1'b0;
            end else if (ins != 32'h1050_0073) model_trap(p, 32'd2, 1'b1);
          end else if (f3 == 3'b100) begin
            model_trap(p, 32'd2, 1'b1);
          end else begin
            wr = (f3[1:0] == 2'b01) || (rs1f != 5'd0);
            if (!csr_known(a) || (wr && ((a[11:10] == 2'b11) || (a == 12'h344)))) begin
              model_trap(p, 32'd2, 1'b1);
            end else begin
              old  = csr_read(a, ir);
              opnd = f3[2] ? {27'b0, rs1f} : r1;
              if (f3[1:0] == 2'b01)      nv = opnd;
              else if (f3[1:0] == 2'b10) nv = old | opnd;
              else                       nv = old & ~opnd;
              if (wr) begin
                case (a)
                  12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                  12'h304: m_meie = nv[11];
                  12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                  12'h340: m_mscratch = nv;
                  12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                  12'h342: m_mcause = nv;
                  12'hB00: begin wr_lo = 1'b1; lo_val = nv; end
                  12'hB80: begin wr_hi = 1'b1; hi_val = nv; end
                  default: ;
                endcase
              end
              if (rdi != 5'd0) exp_q.push_back(mk(1'b1, old, 1'b0, 32'h0, 1'b0));
            end
          end
        end
      end
      inc = m_cycle + 64'd1;
      m_cycle = {wr_hi ? hi_val : inc[63:32], wr_lo ? lo_val : inc[31:0]};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] csr_op(input logic [2:0] f3, input logic [4:0] rdi,
                                         input logic [4:0] rs1f, input logic [11:0] a);
    return {a, rs1f, f3, rdi, 7'h73};
  endfunction

  task automatic run(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                     input logic ir);
    step(1'b1, ins, p, r1, ir, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: pops one expectation for every cycle the DUT presents a response.
  always @(negedge clk) begin
    if (rd_wen === 1'b1 || redirect === 1'b1 || illegal === 1'b1) begin
      txn_count++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: rd_wen=%b redirect=%b illegal=%b, required no response",
                 rd_wen, redirect, illegal);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] txn %0d: rd_wen=%b rd_data=%h redirect=%b redirect_pc=%h illegal=%b",
                 txn_count, rd_wen, rd_data, redirect, redirect_pc, illegal);
        check("rd_wen", 32'(rd_wen), 32'(mon_e.rd_wen));
        check("redirect", 32'(redirect), 32'(mon_e.redirect));
        check("illegal", 32'(illegal), 32'(mon_e.illegal));
        if (mon_e.rd_wen)   check("rd_data", rd_data, mon_e.rd_data);
        if (mon_e.redirect) check("redirect_pc", redirect_pc, mon_e.redirect_pc);
      end
    end
  end

  initial begin
    int          sel;
    logic [31:0] r;
    logic [2:0]  f3;
    logic [4:0]  rdi, rs1f;
    logic [31:0] ins;
    int          k;

    addr_pool[0] = 12'h300; addr_pool[1]  = 12'h304; addr_pool[2]  = 12'h305;
    addr_pool[3] = 12'h340; addr_pool[4]  = 12'h341; addr_pool[5]  = 12'h342;
    addr_pool[6] = 12'h344; addr_pool[7]  = 12'hB00; addr_pool[8]  = 12'hB80;
    addr_pool[9] = 12'hB01; addr_pool[10] = 12'hF11; addr_pool[11] = 12'hC00;

    @(negedge clk);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    // Reset state of all outputs.
    check("rst_rd_wen", 32'(rd_wen), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h305), 32'h0, 32'h0, 1'b0);   // mtvec reset value

    // mscratch write then read-back without write.
    run(csr_op(3'b001, 5'd5, 5'd1, 12'h340), 32'h0, 32'hDEAD_BEEF, 1'b0);
    run(csr_op(3'b010, 5'd6, 5'd0, 12'h340), 32'h0, 32'h1234_5678, 1'b0);
    run(csr_op(3'b010, 5'd7, 5'd0, 12'h340), 32'h0, 32'h0, 1'b0);

    // ecall with mtvec=0x100 at pc 0x40.
    run(csr_op(3'b001, 5'd0, 5'd2, 12'h305), 32'h0, 32'h0000_0100, 1'b0);
    run(32'h0000_0073, 32'h40, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0073, 32'h44, 32'h0, 1'b0, 1'b0);          // ignored while busy
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h341), 32'h0, 32'h0, 1'b0);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h342), 32'h0, 32'h0, 1'b0);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h300), 32'h0, 32'h0, 1'b0);

    // MIE=1, ecall, mret restores MIE.
    run(csr_op(3'b110, 5'd0, 5'd8, 12'h300), 32'h0, 32'h0, 1'b0);
    run(32'h0000_0073, 32'h0000_0044, 32'h0, 1'b0);
    idle(1);
    run(32'h3020_0073, 32'h0000_0100, 32'h0, 1'b0);
    idle(1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h300), 32'h0, 32'h0, 1'b0);

    // External interrupt pre-empts an instruction at pc 0x80.
    run(csr_op(3'b010, 5'd0, 5'd1, 12'h304), 32'h0, 32'h0000_0800, 1'b0);
    run(csr_op(3'b001, 5'd9, 5'd1, 12'h340), 32'h80, 32'h5555_AAAA, 1'b1);
    idle(1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h342), 32'h0, 32'h0, 1'b1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h341), 32'h0, 32'h0, 1'b1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h340), 32'h0, 32'h0, 1'b1);
    run(csr_op(3'b010, 5'd3, 5'd0, 12'h344), 32'h0, 32'h0, 1'b1);   // read mip

    // Illegal encodings.
    run(csr_op(3'b001, 5'd4, 5'd1, 12'hB01), 32'h200, 32'h1, 1'b0);
    idle(1);
    run(csr_op(3'b001, 5'd4, 5'd1, 12'hF11), 32'h204, 32'h1, 1'b0);
    idle(1);
    run(32'h1020_0073, 32'h208, 32'h0, 1'b0);
    idle(1);
    run(csr_op(3'b001, 5'd4, 5'd1, 12'h344), 32'h20C, 32'h1, 1'b0);
    idle(1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h342), 32'h0, 32'h0, 1'b0);
    run(32'h1050_0073, 32'h0, 32'h0, 1'b0);                          // wfi: no response

    // mcycle wrap into mcycleh.
    run(csr_op(3'b010, 5'd1, 5'd0, 12'hB80), 32'h0, 32'h0, 1'b0);
    run(csr_op(3'b001, 5'd0, 5'd1, 12'hB00), 32'h0, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'hB80), 32'h0, 32'h0, 1'b0);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'hB00), 32'h0, 32'h0, 1'b0);

    // Reset during TRAP drops the rest of the trap sequence.
    run(32'h0010_0073, 32'h300, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("redirect_after_rst", 32'(redirect), 32'h0);
    idle(1);
    run(csr_op(3'b010, 5'd1, 5'd0, 12'h305), 32'h0, 32'h0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom;
      sel = $urandom_range(0, 19);
      case (sel)
        0: ins = 32'h0000_0073;
        1: ins = 32'h0010_0073;
        2: ins = 32'h3020_0073;
        3: ins = 32'h1050_0073;
        4: ins = 32'h1020_0073;
        5: ins = {r[31:7], 7'h13};
        6: ins = {r[31:15], 3'b000, r[11:7], 7'h73};
        7: ins = {r[31:15], 3'b100, r[11:7], 7'h73};
        default: begin
          k    = $urandom_range(0, 5);
          f3   = (k < 3) ? 3'(k + 1) : 3'(k + 2);
          rdi  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          rs1f = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          ins  = csr_op(f3, rdi, rs1f, addr_pool[$urandom_range(0, 11)]);
        end
      endcase
      step(($urandom_range(0, 5) != 0), ins, $urandom, $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
